id_ex_skid_stage: RTL and testbench

//  ID->EX pipeline register feeding the execute-stage ALU operands, immediate, pc and op code.
//  Two-entry skid buffer under a valid/ready handshake, so in_ready is a pure register output.

---
 rtl/id_ex_skid_stage_pkg.sv | 22 ++
 rtl/id_ex_skid_stage_pipe_slot.sv | 24 ++
 rtl/id_ex_skid_stage.sv | 117 +++++++++++
 tb/tb_id_ex_skid_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_stage_pkg.sv
// Shared widths, op codes and state encoding for the ID->EX skid stage.
package id_ex_skid_stage_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int PC_W_DEF   = 64;
  localparam int OP_W_DEF   = 5;
  localparam int RD_W_DEF   = 5;

  localparam logic [OP_W_DEF-1:0] OP_NOP = '0;

  // Encoding is {skid_v, main_v}; 2'b10 cannot occur because skid only fills behind main.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

  function automatic int entry_w(input int data_w, input int pc_w, input int op_w, input int rd_w);
    return 3 * data_w + pc_w + op_w + rd_w + 1;
  endfunction

endpackage

// File: rtl/id_ex_skid_stage_pipe_slot.sv
// One pipeline entry: a valid bit plus a payload register that loads only when told to.
module id_ex_skid_stage_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_d,
  input  logic         load,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) data_q <= data_d;
    end
  end

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID->EX register built as a two-entry skid buffer; in_ready depends only on the skid flop.
module id_ex_skid_stage
  import id_ex_skid_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_num1,
  input  logic [DATA_W-1:0] in_num2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_rf_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_num1,
  output logic [DATA_W-1:0] out_num2,
  output logic [DATA_W-1:0] out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic [OP_W-1:0]   out_op,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_rf_wen,
  output stage_state_e      dbg_state
);

  localparam int ENTRY_W = entry_w(DATA_W, PC_W, OP_W, RD_W);

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_entry_d;
  logic [ENTRY_W-1:0] main_entry_q;
  logic [ENTRY_W-1:0] skid_entry_q;
  logic               main_v_d, main_v_q;
  logic               skid_v_d, skid_v_q;
  logic               main_load, skid_load;
  logic               accept, issue;

  assign in_entry  = {in_num1, in_num2, in_imm, in_pc, in_op, in_rd, in_rf_wen};
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign accept    = in_valid & in_ready;
  assign issue     = main_v_q & out_ready;
  assign dbg_state = stage_state_e'({skid_v_q, main_v_q});

  assign {out_num1, out_num2, out_imm, out_pc, out_op, out_rd, out_rf_wen} = main_entry_q;

  always_comb begin
    main_v_d     = main_v_q;
    skid_v_d     = skid_v_q;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_entry_d = in_entry;
    if (flush) begin
      // Payload is left in place; clearing the valid bits is enough to drop everything.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case (dbg_state)
        ST_EMPTY: begin
          if (accept) begin
            main_v_d  = 1'b1;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && !issue) begin
            skid_v_d  = 1'b1;
            skid_load = 1'b1;
          end else if (issue && !accept) begin
            main_v_d = 1'b0;
          end else if (accept && issue) begin
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (issue) begin
            skid_v_d     = 1'b0;
            main_load    = 1'b1;
            main_entry_d = skid_entry_q;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  id_ex_skid_stage_pipe_slot #(.W(ENTRY_W)) u_main (
    .clock   (clock),
    .reset   (reset),
    .valid_d (main_v_d),
    .load    (main_load),
    .data_d  (main_entry_d),
    .valid_q (main_v_q),
    .data_q  (main_entry_q)
  );

  id_ex_skid_stage_pipe_slot #(.W(ENTRY_W)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .valid_d (skid_v_d),
    .load    (skid_load),
    .data_d  (in_entry),
    .valid_q (skid_v_q),
    .data_q  (skid_entry_q)
  );

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: handshake, back-pressure, flush and async reset.
module tb_id_ex_skid_stage;
  import id_ex_skid_stage_pkg::*;

  localparam logic [4:0] OP_DIV = 5'd12;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_num1, in_num2, in_imm, in_pc;
  logic [4:0]  in_op, in_rd;
  logic        in_rf_wen;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_num1, out_num2, out_imm, out_pc;
  logic [4:0]  out_op, out_rd;
  logic        out_rf_wen;
  stage_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int issue_cnt = 0;

  logic [63:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] hold_pc, hold_num1, hold_num2, hold_imm;
  logic [10:0] hold_ctl;

  always #5 clock = ~clock;

  id_ex_skid_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num1(in_num1), .in_num2(in_num2), .in_imm(in_imm), .in_pc(in_pc),
    .in_op(in_op), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_num1(out_num1), .out_num2(out_num2), .out_imm(out_imm), .out_pc(out_pc),
    .out_op(out_op), .out_rd(out_rd), .out_rf_wen(out_rf_wen),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] pc, input logic [4:0] op,
                       input logic [63:0] n1, input logic [63:0] n2);
    in_valid  = v;
    in_pc     = pc;
    in_op     = op;
    in_num1   = n1;
    in_num2   = n2;
    in_imm    = pc ^ 64'h55;
    in_rd     = pc[6:2];
    in_rf_wen = 1'b1;
  endtask

  // Scoreboard: FIFO order of issued pcs and stability of held outputs, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_pc",   out_pc,   hold_pc);
        check("stall_num1", out_num1, hold_num1);
        check("stall_num2", out_num2, hold_num2);
        check("stall_imm",  out_imm,  hold_imm);
        check("stall_ctl",  {53'd0, out_op, out_rd, out_rf_wen}, {53'd0, hold_ctl});
      end
      if (out_valid && out_ready) begin
        issue_cnt++;
        if (exp_q.size() == 0) check("issue_unexpected", out_pc, 64'hDEAD);
        else check("fifo_order", out_pc, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(in_pc);
      if (flush) exp_q.delete();
      prev_stall = out_valid && !out_ready && !flush;
      hold_pc   = out_pc;
      hold_num1 = out_num1;
      hold_num2 = out_num2;
      hold_imm  = out_imm;
      hold_ctl  = {out_op, out_rd, out_rf_wen};
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    offer(1'b1, 64'h40, 5'd1, 64'd1, 64'd2);

    // 1. reset with in_valid high
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_op", out_op, OP_NOP);
    check("rst_out_pc", out_pc, 64'h0);
    step(); step();
    reset = 1'b0;
    step();
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_pc", out_pc, 64'h40);
    offer(1'b0, 64'h0, 5'd0, 64'd0, 64'd0);
    out_ready = 1'b1;
    step();
    check("t1_drained", out_valid, 1'b0);

    // 2. streaming
    offer(1'b1, 64'h8000_0000, 5'd2, 64'd3, 64'd4);
    step();
    check("t2_valid0", out_valid, 1'b1);
    check("t2_pc0", out_pc, 64'h8000_0000);
    check("t2_ready0", in_ready, 1'b1);
    offer(1'b1, 64'h8000_0004, 5'd3, 64'd5, 64'd6);
    step();
    check("t2_pc1", out_pc, 64'h8000_0004);
    check("t2_ready1", in_ready, 1'b1);
    offer(1'b0, 64'h0, 5'd0, 64'd0, 64'd0);
    step();
    check("t2_drained", out_valid, 1'b0);
    check("t2_queue", exp_q.size(), 0);

    // 3. back-pressure into the skid
    out_ready = 1'b0;
    offer(1'b1, 64'h100, 5'd1, 64'd10, 64'd11);
    step();
    check("t3_pcA", out_pc, 64'h100);
    check("t3_readyA", in_ready, 1'b1);
    offer(1'b1, 64'h104, 5'd2, 64'd12, 64'd13);
    step();
    check("t3_ready_full", in_ready, 1'b0);
    check("t3_state_full", dbg_state, ST_FULL);
    check("t3_hold_pcA", out_pc, 64'h100);
    offer(1'b0, 64'h0, 5'd0, 64'd0, 64'd0);
    step();
    check("t3_still_pcA", out_pc, 64'h100);
    check("t3_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("t3_pcB", out_pc, 64'h104);
    check("t3_ready_again", in_ready, 1'b1);
    step();
    check("t3_drained", out_valid, 1'b0);
    check("t3_queue", exp_q.size(), 0);

    // 4. divide stall for 64 cycles
    out_ready = 1'b0;
    offer(1'b1, 64'h200, OP_DIV, 64'd100, 64'd7);
    step();
    offer(1'b0, 64'h0, 5'd0, 64'd0, 64'd0);
    base = issue_cnt;
    for (int i = 0; i < 64; i++) begin
      check("t4_num1", out_num1, 64'd100);
      check("t4_num2", out_num2, 64'd7);
      check("t4_op", out_op, OP_DIV);
      step();
    end
    check("t4_no_issue", issue_cnt - base, 0);
    out_ready = 1'b1;
    step();
    check("t4_one_issue", issue_cnt - base, 1);
    check("t4_drained", out_valid, 1'b0);

    // 5. flush while full with a third word offered
    out_ready = 1'b0;
    offer(1'b1, 64'h300, 5'd1, 64'd1, 64'd1);
    step();
    offer(1'b1, 64'h304, 5'd1, 64'd2, 64'd2);
    step();
    check("t5_full", in_ready, 1'b0);
    offer(1'b1, 64'h308, 5'd1, 64'd3, 64'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, 64'h0, 5'd0, 64'd0, 64'd0);
    check("t5_flush_valid", out_valid, 1'b0);
    check("t5_flush_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    base = issue_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_reappear", out_valid, 1'b0);
    end
    check("t5_no_issue", issue_cnt - base, 0);
    check("t5_queue", exp_q.size(), 0);

    // 6. asynchronous reset mid-cycle while full
    out_ready = 1'b0;
    offer(1'b1, 64'h400, 5'd1, 64'd1, 64'd1);
    step();
    offer(1'b1, 64'h404, 5'd1, 64'd2, 64'd2);
    step();
    offer(1'b0, 64'h0, 5'd0, 64'd0, 64'd0);
    check("t6_full", in_ready, 1'b0);
    check("t6_valid_before", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 1'b0);
    check("t6_async_ready", in_ready, 1'b1);
    check("t6_async_pc", out_pc, 64'h0);
    step();
    reset = 1'b0;
    step();
    check("t6_after_valid", out_valid, 1'b0);
    check("t6_after_state", dbg_state, ST_EMPTY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
